// File: rtl/line_window_reader_if.sv
// Read-side bundle between line_window_reader and its line buffers / window consumer.
interface line_window_reader_if #(
    parameter int ADDR_W = 11
);
    logic              frame_start;
    logic              row_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data0;
    logic [7:0]        rd_data1;
    logic [7:0]        rd_data2;
    logic [71:0]       win;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              row_done;
    logic [1:0]        rot;

    modport master (
        input  frame_start, row_start, rd_data0, rd_data1, rd_data2, out_ready,
        output rd_addr, win, out_valid, busy, row_done, rot
    );

    modport slave (
        output frame_start, row_start, rd_data0, rd_data1, rd_data2, out_ready,
        input  rd_addr, win, out_valid, busy, row_done, rot
    );
endinterface

// File: rtl/line_window_reader.sv
// Walks one line across three rotating line buffers and emits a sliding 3x3 window
// per column with a valid/ready handshake.
module line_window_reader #(
    parameter int LINE_W = 1600,
    parameter int ADDR_W = 11
) (
    input logic                 clk,
    input logic                 rst,
    line_window_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic              adv;
    logic              accept;
    logic              last_col;
    logic [7:0]        top, mid, bot;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic [71:0]       win_p0;
    logic              vld_p0;
    logic              row_done_p0;
    logic [1:0]        rot_p0;

    assign accept   = vld_p0 & bus.out_ready;
    assign last_col = (rd_addr_p0 == ADDR_W'(LINE_W - 1));

    // Buffer rot supplies the top row; the other two follow in ring order.
    always_comb begin
        top = bus.rd_data0;
        mid = bus.rd_data1;
        bot = bus.rd_data2;
        case (rot_p0)
            2'd1: begin top = bus.rd_data1; mid = bus.rd_data2; bot = bus.rd_data0; end
            2'd2: begin top = bus.rd_data2; mid = bus.rd_data0; bot = bus.rd_data1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.row_start) state_nxt = PRIME;
            PRIME:   if (adv && rd_addr_p0 == ADDR_W'(1)) state_nxt = RUN;
            RUN:     if (adv && last_col) state_nxt = FLUSH;
            FLUSH:   if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A column is taken whenever the output slot is free or being drained this edge.
    always_comb begin
        adv      = 1'b0;
        bus.busy = (state != IDLE);
        if (state == PRIME || state == RUN)
            adv = ~(vld_p0 & ~bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_p0  <= '0;
            win_p0      <= '0;
            vld_p0      <= 1'b0;
            row_done_p0 <= 1'b0;
            rot_p0      <= 2'd0;
        end else begin
            row_done_p0 <= (state == FLUSH) && accept;
            if (state == IDLE && bus.frame_start)
                rot_p0 <= 2'd0;
            if (state == FLUSH && accept)
                rot_p0 <= (rot_p0 == 2'd2) ? 2'd0 : rot_p0 + 2'd1;
            if (adv) begin
                win_p0     <= {bot, win_p0[71:56], mid, win_p0[47:32], top, win_p0[23:8]};
                rd_addr_p0 <= last_col ? '0 : rd_addr_p0 + ADDR_W'(1);
            end
            if (adv && state == RUN)
                vld_p0 <= 1'b1;
            else if (accept)
                vld_p0 <= 1'b0;
        end
    end

    assign bus.rd_addr   = rd_addr_p0;
    assign bus.win       = win_p0;
    assign bus.out_valid = vld_p0;
    assign bus.row_done  = row_done_p0;
    assign bus.rot       = rot_p0;
endmodule

// File: tb/tb_line_window_reader.sv
// Directed and randomized bench for line_window_reader with a small line and modelled line buffers.
module tb_line_window_reader;
    localparam int LW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_window_reader_if #(.ADDR_W(AW)) bus();
    line_window_reader #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [3][LW];

    // Line buffers sample the address on the falling edge.
    always @(negedge clk) begin
        bus.rd_data0 = mem[0][bus.rd_addr];
        bus.rd_data1 = mem[1][bus.rd_addr];
        bus.rd_data2 = mem[2][bus.rd_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    int exp_rot  = 0;

    logic              s_valid, s_hs, s_done;
    logic [71:0]       s_win;
    logic [AW-1:0]     s_addr;
    logic [1:0]        s_rot;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Window k covers columns k..k+2; row r comes from buffer (rot+r) mod 3.
    function automatic logic [71:0] exp_win(input int r0, input int k);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = mem[(r0 + r) % 3][k + c];
        return w;
    endfunction

    task automatic cyc();
        @(negedge clk);
        s_valid = bus.out_valid;
        s_hs    = bus.out_valid && bus.out_ready;
        s_win   = bus.win;
        s_addr  = bus.rd_addr;
        s_done  = bus.row_done;
        s_rot   = bus.rot;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit rnd);
        for (int n = 0; n < 3; n++)
            for (int a = 0; a < LW; a++)
                mem[n][a] = rnd ? 8'($urandom) : 8'(16 * n + a);
    endtask

    // mode 0: always ready, 1: stall 4 cycles on the 2nd window, 2: random ready
    task automatic run_row(input int mode, input bit inject, input bit with_fs, input int abort_at);
        int got = 0, first = -1, last = -1, nvalid = 0, stall = 0;
        bit fin = 0, held = 0;
        logic [71:0]   hw;
        logic [AW-1:0] ha;
        hw = '0;
        ha = '0;
        if (with_fs) exp_rot = 0;
        bus.row_start   = 1'b1;
        bus.frame_start = with_fs;
        @(posedge clk);
        #1;
        bus.row_start   = 1'b0;
        bus.frame_start = 1'b0;
        for (int i = 0; i < 80 && !fin; i++) begin
            case (mode)
                1: if (got == 1 && stall < 4) begin bus.out_ready = 1'b0; stall++; end
                   else bus.out_ready = 1'b1;
                2: bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b1;
            endcase
            bus.row_start   = inject && got == 2;
            bus.frame_start = inject && got == 2;
            cyc();
            if (s_valid) begin
                nvalid++;
                if (first < 0) first = i;
                last = i;
                chki("rot_in_row", int'(s_rot), exp_rot);
            end
            if (mode == 1 && s_valid && !bus.out_ready) begin
                if (held) begin
                    chk("stall_win", s_win, hw);
                    chki("stall_addr", int'(s_addr), int'(ha));
                end
                hw = s_win;
                ha = s_addr;
                held = 1;
            end
            if (s_hs) begin
                chk($sformatf("win_r%0d_k%0d", exp_rot, got), s_win, exp_win(exp_rot, got));
                got++;
            end
            if (s_done) fin = 1;
            if (abort_at > 0 && got == abort_at) begin
                bus.row_start   = 1'b0;
                bus.frame_start = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chki("abort_valid", int'(bus.out_valid), 0);
                chki("abort_busy", int'(bus.busy), 0);
                chki("abort_addr", int'(bus.rd_addr), 0);
                chk("abort_win", bus.win, 72'd0);
                rst = 1'b0;
                exp_rot = 0;
                bus.out_ready = 1'b1;
                return;
            end
        end
        bus.out_ready   = 1'b1;
        bus.row_start   = 1'b0;
        bus.frame_start = 1'b0;
        chki("row_done_seen", int'(fin), 1);
        chki("win_count", got, LW - 2);
        if (mode == 0) begin
            chki("first_valid_edge", first, 3);
            chki("valid_cycles", nvalid, LW - 2);
            chki("last_valid_edge", last, 3 + LW - 3);
        end
        exp_rot = (exp_rot + 1) % 3;
        chki("rot_after_row", int'(bus.rot), exp_rot);
        cyc();
        chki("row_done_pulse", int'(s_done), 0);
        chki("idle_busy", int'(bus.busy), 0);
        chki("idle_addr", int'(bus.rd_addr), 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.row_start   = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready   = 1'b1;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        chki("rst_addr", int'(bus.rd_addr), 0);
        chki("rst_valid", int'(bus.out_valid), 0);
        chki("rst_busy", int'(bus.busy), 0);
        chki("rst_rot", int'(bus.rot), 0);
        chki("rst_done", int'(bus.row_done), 0);
        chk("rst_win", bus.win, 72'd0);
        rst = 1'b0;
        cyc();

        // Straight stream, then backpressure, then the third rotation.
        run_row(0, 0, 0, 0);
        run_row(1, 0, 0, 0);
        run_row(0, 0, 0, 0);
        chki("rot_wrapped", int'(bus.rot), 0);

        // frame_start alone in IDLE after a row
        run_row(0, 0, 0, 0);
        bus.frame_start = 1'b1;
        cyc();
        bus.frame_start = 1'b0;
        exp_rot = 0;
        chki("frame_clear_rot", int'(bus.rot), 0);
        run_row(0, 0, 0, 0);

        // frame_start together with row_start from rot=1
        run_row(0, 0, 1, 0);

        // Starts pulsed mid-row from rot=1
        chki("pre_inject_rot", int'(bus.rot), 1);
        run_row(0, 1, 0, 0);

        // Reset after three windows, then a clean row
        fill(1);
        run_row(0, 0, 0, 3);
        cyc();
        run_row(0, 0, 0, 0);

        for (int n = 0; n < 5; n++) begin
            fill(1);
            run_row(2, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
